mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Takes over MULT/MULTU from the single-cycle combinational ALU and adds DIV/DIVU, MTHI/MTLO, a start/ready/done handshake and registered results.
- Sits beside the ALU in the execute stage. The pipeline stalls on ready=0 and reads hi/lo directly for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_iter.sv | 37 +++
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 tb/tb_mult_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encoding and FSM states.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_iter(logic [2:0] op);
    return op <= MDU_DIVU;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// One combinational step of shift-add multiply or
// restoring divide.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0]   sh_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] opnd_o,
  output logic [WIDTH-1:0]   sh_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ok;

  always_comb begin
    rem_sh = {acc_i[WIDTH-1:0], sh_i[WIDTH-1]};
    ok     = rem_sh >= {1'b0, opnd_i[WIDTH-1:0]};
    // result is below 2^WIDTH whenever ok, so wrap is safe
    sub    = rem_sh[WIDTH-1:0] - opnd_i[WIDTH-1:0];
    if (div_i) begin
      acc_o  = {{WIDTH{1'b0}}, ok ? sub : rem_sh[WIDTH-1:0]};
      opnd_o = opnd_i;
      sh_o   = {sh_i[WIDTH-2:0], ok};
    end else begin
      acc_o  = sh_i[0] ? acc_i + opnd_i : acc_i;
      opnd_o = opnd_i << 1;
      sh_o   = sh_i >> 1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/DIV unit with HI/LO registers.
// Define MDU_EARLY_OUT_EN to end multiplies once the multiplier is exhausted.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, opnd_q, opnd_d;
  logic [2*WIDTH-1:0] it_acc, it_opnd, prod;
  logic [WIDTH-1:0] sh_q, sh_d, it_sh;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] mag0, mag1, quo, rem;
  logic div_q, div_d, neg_q, neg_d;
  logic rneg_q, rneg_d, dz_q, dz_d;
  logic done_q, done_d;
  logic is_sgn, is_div, last;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .sh_i   (sh_q),
    .acc_o  (it_acc),
    .opnd_o (it_opnd),
    .sh_o   (it_sh)
  );

  assign is_sgn = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign mag0 = (is_sgn && in0[WIDTH-1]) ? -in0 : in0;
  assign mag1 = (is_sgn && in1[WIDTH-1]) ? -in1 : in1;

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo = neg_q ? -sh_q : sh_q;
  assign rem = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

`ifdef MDU_EARLY_OUT_EN
  assign last = (cnt_q == CNT_W'(WIDTH - 1)) ||
                (!div_q && (it_sh == '0));
`else
  assign last = cnt_q == CNT_W'(WIDTH - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    sh_d    = sh_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_iter(op): begin
              state_d = S_CALC;
              cnt_d   = '0;
              div_d   = is_div;
              neg_d   = is_sgn && (in0[WIDTH-1] ^ in1[WIDTH-1]);
              rneg_d  = is_sgn && in0[WIDTH-1];
              dz_d    = in1 == '0;
              acc_d   = '0;
              opnd_d  = {{WIDTH{1'b0}}, is_div ? mag1 : mag0};
              sh_d    = is_div ? mag0 : mag1;
            end
            op == MDU_MTHI: hi_d = in0;
            op == MDU_MTLO: lo_d = in0;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d  = it_acc;
        opnd_d = it_opnd;
        sh_d   = it_sh;
        cnt_d  = cnt_q + 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // divide by zero keeps the raw all-ones quotient
          lo_d = dz_q ? '1 : quo;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      sh_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign ready = state_q == S_IDLE;
  assign busy  = !ready;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corners,
// random ops, held start and mid-operation reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic ready, busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int due;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(logic [2:0] o,
                                          logic [31:0] a,
                                          logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MDU_MULT: return 64'(sa * sb);
      MDU_MULTU: return 64'(ua * ub);
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  function automatic int lat(logic [2:0] o, logic [31:0] b);
    logic [31:0] m;
    int n;
    m = (o == MDU_MULT && b[31]) ? -b : b;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    if (EARLY && o <= MDU_MULTU) return (n == 0 ? 1 : n) + 1;
    return W + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_is_not_ready", 64'(busy), 64'(!ready));
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("hi_lo", {hi, lo}, {e.hi, e.lo});
          check("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    logic [63:0] r;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 64'(ready), 64'(1));
      return;
    end
    op = o;
    in0 = a;
    in1 = b;
    start = 1'b1;
    if (is_iter(o)) begin
      r = ref_res(o, a, b);
      sbq.push_back('{hi: r[63:32], lo: r[31:0],
                      due: cyc + 1 + lat(o, b)});
      mhi = r[63:32];
      mlo = r[31:0];
    end else if (o == MDU_MTHI) begin
      mhi = a;
    end else if (o == MDU_MTLO) begin
      mlo = a;
    end
    @(negedge clk);
    start = 1'b0;
    if (!is_iter(o)) begin
      check("single_cycle_hilo", {hi, lo}, {mhi, mlo});
      check("single_cycle_ready", 64'(ready), 64'(1));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_ready", 64'(ready), 64'(1));
    check("reset_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(MDU_MULT, 32'hFFFF_FFFA, 32'd7);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MDU_DIVU, 32'd100, 32'd7);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(MDU_DIVU, 32'd5, 32'd0);
    issue(MDU_DIV, 32'hFFFF_FFFB, 32'd0);
    issue(MDU_MULTU, 32'd5, 32'd3);
    issue(MDU_MULT, 32'h1234_5678, 32'd0);
    drain();

    issue(MDU_MTHI, 32'h1234, 32'h0);
    issue(MDU_MTLO, 32'h5678, 32'h0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    issue(3'd7, 32'hCAFE_F00D, 32'h2);

    // start held high through busy: only one op accepted
    op = MDU_MULTU;
    in0 = 32'd3;
    in1 = 32'd5;
    start = 1'b1;
    sbq.push_back('{hi: 32'h0, lo: 32'd15,
                    due: cyc + 1 + lat(MDU_MULTU, 32'd5)});
    @(negedge clk);
    n = 0;
    while (!ready && n < 200) begin
      check("held_start_busy", 64'(busy), 64'(1));
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    mhi = 32'h0;
    mlo = 32'd15;
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end
    drain();

    issue(MDU_MTHI, 32'hA5A5_0001, 32'h0);
    issue(MDU_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midop_reset_hi", 64'(hi), 64'(0));
    check("midop_reset_lo", 64'(lo), 64'(0));
    check("midop_reset_ready", 64'(ready), 64'(1));
    check("midop_reset_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_hilo", {hi, lo}, 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
